loopback_frame_checker: RTL and testbench
=========================================

Name: loopback_frame_checker

Overview:
Self-checking loopback tester for the 802.11a TX→RX chain. It generates PRBS-7 frames, drives them into the Transmitter through TxStart/TxData, and receives the Receiver's bit stream on RxValid/RxData. Each received bit is compared against a locally regenerated reference, and the block reports bit, frame and timeout errors. It supersedes the fixed open-loop DUT wrapper and allows a parametrised frame length, frame count and timeout.

Parameters:
FRAME_BITS, 96, payload bits per frame (≥1)
SEED, 7'h7F, initial PRBS-7 state (must be nonzero)
TIMEOUT, 1024, max cycles between received bits in WAIT_RX before abort
CNT_W, 16, width of error counters and NumFrames

Ports:
Clock  input  1  single system clock, rising edge
Reset  input  1  synchronous, active-high reset
Run  input  1  one-cycle start pulse; ignored unless IDLE or DONE
NumFrames  input  CNT_W  frames to send; sampled when Run is accepted
TxStart  output  1  one-cycle start pulse to Transmitter
TxData  output  1  serial payload bit to Transmitter
RxValid  input  1  receiver output bit valid
RxData  input  1  receiver output bit
RxError  input  1  receiver error flag; sampled every cycle
Busy  output  1  test in progress
Done  output  1  level; high in DONE until next Run or Reset
Pass  output  1  valid while Done: no bit, frame or timeout error
Timeout  output  1  sticky; test aborted on timeout
BitErrors  output  CNT_W  saturating mismatched-bit count
FrameErrors  output  CNT_W  saturating count of frames with any error

Behaviour:
- Clock and reset: one clock (Clock). Reset is synchronous and active-high. Reset on any cycle, including mid-frame, forces state IDLE on the next edge. All outputs go to 0 and both LFSRs load SEED.
- PRBS-7, x^7+x^6+1. Output bit = lfsr[6]. Next state = {lfsr[5:0], lfsr[6]^lfsr[5]}. TX and RX LFSRs are separate registers.
- FSM states: IDLE, TX_START, TX_DATA, WAIT_RX, DONE.
- IDLE/DONE + Run:
  - NumFrames==0 → DONE next cycle, Pass=1, counters cleared.
  - Otherwise → TX_START. Clear counters, Timeout, Done and the frame counter; Busy=1.
- TX_START (1 cycle):
  - TxStart=1.
  - Snapshot the TX LFSR state into the RX reference LFSR and clear the RX bit counter.
  - → TX_DATA.
- TX_DATA (exactly FRAME_BITS cycles):
  - TxData = TX lfsr[6]; the TX LFSR advances every cycle.
  - After the last bit → WAIT_RX.
  - TxData=0 in all other states.
- RX path: active in TX_DATA and WAIT_RX while rx_count < FRAME_BITS.
  - On RxValid: compare RxData with the ref lfsr[6], advance the ref LFSR, increment rx_count.
  - A mismatch increments BitErrors and sets the frame_bad flag.
  - RxValid in any other state, or once rx_count==FRAME_BITS, is ignored.
- RxError: high in TX_START/TX_DATA/WAIT_RX sets frame_bad.
- WAIT_RX:
  - Idle counter resets on each RxValid and increments otherwise.
  - Idle counter reaches TIMEOUT → set Timeout, increment FrameErrors, → DONE.
  - rx_count==FRAME_BITS → FrameErrors += frame_bad, clear frame_bad, increment frame counter.
    - Frame counter == NumFrames → DONE.
    - Otherwise → TX_START on the next cycle.
- Simultaneous last bit and timeout in the same cycle: the completed bit wins, no timeout.
- Counters saturate at 2^CNT_W−1 and do not wrap.
- DONE:
  - Busy=0, Done=1.
  - Pass = (BitErrors==0 && FrameErrors==0 && !Timeout).
  - Outputs hold until Run or Reset.
- Latency: Run at edge t → TxStart high in cycle t+1 → first TxData in cycle t+2.

Test Plan:
- Clean loopback: RxData/RxValid = TxData delayed 5 cycles, FRAME_BITS=96, NumFrames=3 → 3 TxStart pulses, Done=1, Pass=1, BitErrors=0, FrameErrors=0. First 7 TxData bits of frame 1 are 1.
- Single flip of frame 2, bit 10 → BitErrors=1, FrameErrors=1, Pass=0. Frames 1 and 3 are error-free.
- RxError pulsed once during frame 1, data clean → BitErrors=0, FrameErrors=1, Pass=0.
- RxValid stopped after 50 bits, TIMEOUT=64 → Timeout=1 and Done exactly 64 cycles after the last RxValid. FrameErrors=1, Pass=0.
- NumFrames=0 with Run → Done=1, Pass=1 next cycle, no TxStart. A Run while Busy is ignored; a Run in DONE restarts with cleared counters.
- Reset asserted mid-TX_DATA → next cycle all outputs 0, state IDLE. A following Run repeats a frame identical to frame 1 (LFSR reseeded to SEED).

Source files
------------

// File: rtl/loopback_frame_checker_if.sv
// Serial link between the loopback checker and the 802.11a TX->RX chain.
// master = checker side, slave = transmitter/receiver side.
interface loopback_frame_checker_if;
  logic TxStart;
  logic TxData;
  logic RxValid;
  logic RxData;
  logic RxError;

  modport master (output TxStart, output TxData,
                  input  RxValid, input  RxData, input RxError);
  modport slave  (input  TxStart, input  TxData,
                  output RxValid, output RxData, output RxError);
endinterface

// File: rtl/loopback_frame_checker.sv
// PRBS-7 loopback tester: sends frames to the transmitter and checks the
// receiver output bit-by-bit against a regenerated reference sequence.
module loopback_frame_checker #(
  parameter int         FRAME_BITS = 96,
  parameter logic [6:0] SEED       = 7'h7F,
  parameter int         TIMEOUT    = 1024,
  parameter int         CNT_W      = 16
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Run,
  input  logic [CNT_W-1:0]         NumFrames,
  loopback_frame_checker_if.master lnk,
  output logic                     Busy,
  output logic                     Done,
  output logic                     Pass,
  output logic                     Timeout,
  output logic [CNT_W-1:0]         BitErrors,
  output logic [CNT_W-1:0]         FrameErrors
);
  localparam int BIT_W  = $clog2(FRAME_BITS + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_TX_START, S_TX_DATA, S_WAIT_RX, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [6:0]         r_tx_lfsr, r_rx_lfsr;
  logic [BIT_W-1:0]   r_tx_cnt, r_rx_cnt;
  logic [IDLE_W-1:0]  r_idle_cnt;
  logic [CNT_W-1:0]   r_frame_cnt, r_num_frames, r_bit_errors, r_frame_errors;
  logic               r_frame_bad, r_timeout;

  logic               w_active, w_rx_take, w_mismatch, w_rx_err, w_bad_nxt;
  logic               w_frame_done, w_last_frame, w_idle_hit, w_tx_last, w_run_ok;
  logic [BIT_W-1:0]   w_rx_cnt_nxt;
  logic [IDLE_W-1:0]  w_idle_nxt;

  function automatic logic [6:0] prbs_next(input logic [6:0] s);
    return {s[5:0], s[6] ^ s[5]};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
  endfunction

  assign w_active     = (r_state == S_TX_DATA) || (r_state == S_WAIT_RX);
  assign w_rx_take    = w_active && lnk.RxValid && (r_rx_cnt < BIT_W'(FRAME_BITS));
  assign w_mismatch   = w_rx_take && (lnk.RxData != r_rx_lfsr[6]);
  assign w_rx_err     = lnk.RxError && (w_active || (r_state == S_TX_START));
  assign w_bad_nxt    = r_frame_bad | w_mismatch | w_rx_err;
  assign w_rx_cnt_nxt = r_rx_cnt + BIT_W'(w_rx_take);
  assign w_tx_last    = (r_tx_cnt == BIT_W'(FRAME_BITS - 1));
  assign w_last_frame = ((r_frame_cnt + CNT_W'(1)) == r_num_frames);
  assign w_run_ok     = Run && ((r_state == S_IDLE) || (r_state == S_DONE));

  // The idle count also runs during TX_DATA so a stall that starts mid-frame
  // is timed from the last received bit, not from the end of transmission.
  assign w_idle_nxt   = lnk.RxValid ? '0 :
                        (r_idle_cnt == IDLE_W'(TIMEOUT)) ? r_idle_cnt : r_idle_cnt + IDLE_W'(1);
  // A bit that completes the frame takes priority over a coincident timeout.
  assign w_frame_done = (r_state == S_WAIT_RX) && (w_rx_cnt_nxt == BIT_W'(FRAME_BITS));
  assign w_idle_hit   = (r_state == S_WAIT_RX) && !w_frame_done && (w_idle_nxt == IDLE_W'(TIMEOUT));

  always_comb begin
    w_state_nxt = r_state;
    Busy        = 1'b0;
    Done        = 1'b0;
    lnk.TxStart = 1'b0;
    lnk.TxData  = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        Done = (r_state == S_DONE);
        if (Run) w_state_nxt = (NumFrames == '0) ? S_DONE : S_TX_START;
      end
      S_TX_START: begin
        Busy        = 1'b1;
        lnk.TxStart = 1'b1;
        w_state_nxt = S_TX_DATA;
      end
      S_TX_DATA: begin
        Busy       = 1'b1;
        lnk.TxData = r_tx_lfsr[6];
        if (w_tx_last) w_state_nxt = S_WAIT_RX;
      end
      S_WAIT_RX: begin
        Busy = 1'b1;
        if (w_frame_done)    w_state_nxt = w_last_frame ? S_DONE : S_TX_START;
        else if (w_idle_hit) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign Pass        = Done && (r_bit_errors == '0) && (r_frame_errors == '0) && !r_timeout;
  assign Timeout     = r_timeout;
  assign BitErrors   = r_bit_errors;
  assign FrameErrors = r_frame_errors;

  always_ff @(posedge Clock) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_tx_lfsr      <= SEED;
      r_rx_lfsr      <= SEED;
      r_tx_cnt       <= '0;
      r_rx_cnt       <= '0;
      r_idle_cnt     <= '0;
      r_frame_cnt    <= '0;
      r_num_frames   <= '0;
      r_bit_errors   <= '0;
      r_frame_errors <= '0;
      r_frame_bad    <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      if (r_state == S_TX_START) begin
        r_rx_lfsr  <= r_tx_lfsr;
        r_rx_cnt   <= '0;
        r_tx_cnt   <= '0;
        r_idle_cnt <= '0;
      end
      if (r_state == S_TX_DATA) begin
        r_tx_lfsr <= prbs_next(r_tx_lfsr);
        r_tx_cnt  <= r_tx_cnt + BIT_W'(1);
      end
      if (w_active) r_idle_cnt <= w_idle_nxt;
      if (w_rx_take) begin
        r_rx_lfsr <= prbs_next(r_rx_lfsr);
        r_rx_cnt  <= w_rx_cnt_nxt;
      end
      r_bit_errors <= sat_inc(r_bit_errors, w_mismatch);
      if (w_frame_done) begin
        r_frame_errors <= sat_inc(r_frame_errors, w_bad_nxt);
        r_frame_cnt    <= r_frame_cnt + CNT_W'(1);
        r_frame_bad    <= 1'b0;
      end else begin
        if (w_mismatch || w_rx_err) r_frame_bad <= 1'b1;
        if (w_idle_hit) begin
          r_frame_errors <= sat_inc(r_frame_errors, 1'b1);
          r_timeout      <= 1'b1;
        end
      end
      if (w_run_ok) begin
        r_num_frames   <= NumFrames;
        r_frame_cnt    <= '0;
        r_bit_errors   <= '0;
        r_frame_errors <= '0;
        r_frame_bad    <= 1'b0;
        r_timeout      <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_loopback_frame_checker.sv
// Bench for loopback_frame_checker: a 5-cycle loopback channel with optional
// bit flips, RxError pulses and RxValid stalls, driven from a vector table.
module tb_loopback_frame_checker;
  localparam int FB = 96;
  localparam int TO = 64;
  localparam int CW = 16;
  localparam int D  = 5;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          Run   = 1'b0;
  logic [CW-1:0] NumFrames = '0;
  logic          Busy, Done, Pass, Timeout;
  logic [CW-1:0] BitErrors, FrameErrors;

  loopback_frame_checker_if lnk();

  loopback_frame_checker #(.FRAME_BITS(FB), .SEED(7'h7F), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .Clock(Clock), .Reset(Reset), .Run(Run), .NumFrames(NumFrames), .lnk(lnk),
    .Busy(Busy), .Done(Done), .Pass(Pass), .Timeout(Timeout),
    .BitErrors(BitErrors), .FrameErrors(FrameErrors)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Channel impairment knobs (frame numbers start at 1, -1 disables).
  int flip_fr = -1, flip_bit = -1, err_fr = -1, err_bit = -1, stop_fr = -1, stop_bit = 0;
  int run_seq = 0;

  // Channel state, owned by the driver process.
  int          seen_seq = 0, fr = 0, rxi = 0, n_start = 0, tx_left = 0, txi = 0;
  int          last_rx_edge = 0;
  logic [FB-1:0] cap = '0;
  logic        dv [0:D];
  logic        dd [0:D];

  initial begin
    logic v;
    lnk.RxValid = 1'b0;
    lnk.RxData  = 1'b0;
    lnk.RxError = 1'b0;
    for (int i = 0; i <= D; i++) begin dv[i] = 1'b0; dd[i] = 1'b0; end
    forever begin
      @(negedge Clock);
      if (seen_seq != run_seq) begin
        seen_seq = run_seq; fr = 0; n_start = 0; cap = '0;
      end
      v = (tx_left > 0);
      if (v) begin
        if (fr == 1) cap[txi] = lnk.TxData;
        txi++;
        tx_left--;
      end
      if (!Busy) begin
        v = 1'b0; tx_left = 0;
        for (int i = 0; i <= D; i++) dv[i] = 1'b0;
      end
      if (lnk.TxStart) begin
        tx_left = FB; txi = 0; fr++; rxi = 0; n_start++;
      end
      for (int i = D; i > 0; i--) begin dv[i] = dv[i-1]; dd[i] = dd[i-1]; end
      dv[0] = v;
      dd[0] = lnk.TxData;
      lnk.RxValid = 1'b0;
      lnk.RxData  = 1'b0;
      lnk.RxError = 1'b0;
      if (dv[D]) begin
        if (!(fr == stop_fr && rxi >= stop_bit)) begin
          lnk.RxValid  = 1'b1;
          lnk.RxData   = dd[D] ^ (fr == flip_fr && rxi == flip_bit);
          last_rx_edge = cyc + 1;  // index of the edge that samples this bit
        end
        if (fr == err_fr && rxi == err_bit) lnk.RxError = 1'b1;
        rxi++;
      end
    end
  end

  function automatic logic [FB-1:0] prbs_frame(input logic [6:0] seed);
    logic [6:0]    s;
    logic [FB-1:0] f;
    s = seed;
    f = '0;
    for (int i = 0; i < FB; i++) begin
      f[i] = s[6];
      s = {s[5:0], s[6] ^ s[5]};
    end
    return f;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_pulse(input int nf);
    @(negedge Clock);
    run_seq++;
    Run = 1'b1;
    NumFrames = CW'(nf);
    @(negedge Clock);
    Run = 1'b0;
  endtask

  task automatic wait_done(input string name, output int edge_idx);
    edge_idx = -1;
    for (int k = 0; k < 4000; k++) begin
      if (Done) begin edge_idx = cyc; break; end
      @(negedge Clock);
    end
    if (edge_idx < 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s: Done not seen within 4000 cycles", name);
    end
  endtask

  typedef struct {
    int   nf;
    int   flip_fr, flip_bit, err_fr, err_bit, stop_fr, stop_bit;
    int   be, fe;
    logic to, pass;
    int   starts;
  } vec_t;

  vec_t vecs [6];
  logic [FB-1:0] frame1;

  initial begin
    int de;
    frame1 = prbs_frame(7'h7F);

    //          nf  flpF flpB errF errB stpF stpB  be fe to    pass  starts
    vecs[0] = '{3,  -1,  -1,  -1,  -1,  -1,  0,   0, 0, 1'b0, 1'b1, 3};
    vecs[1] = '{3,   2,  10,  -1,  -1,  -1,  0,   1, 1, 1'b0, 1'b0, 3};
    vecs[2] = '{2,  -1,  -1,   1,  20,  -1,  0,   0, 1, 1'b0, 1'b0, 2};
    vecs[3] = '{2,  -1,  -1,  -1,  -1,   1,  50,  0, 1, 1'b1, 1'b0, 1};
    vecs[4] = '{3,   3,  95,  -1,  -1,  -1,  0,   1, 1, 1'b0, 1'b0, 3};
    vecs[5] = '{1,   1,   0,   1,   5,  -1,  0,   1, 1, 1'b0, 1'b0, 1};

    repeat (3) @(negedge Clock);
    check("reset_outputs", {Busy, Done, Pass, Timeout, lnk.TxStart, lnk.TxData, BitErrors, FrameErrors}, '0);
    Reset = 1'b0;
    @(negedge Clock);
    check("idle_outputs", {Busy, Done, Pass, Timeout, lnk.TxStart, lnk.TxData, BitErrors, FrameErrors}, '0);

    for (int i = 0; i < 6; i++) begin
      flip_fr = vecs[i].flip_fr; flip_bit = vecs[i].flip_bit;
      err_fr  = vecs[i].err_fr;  err_bit  = vecs[i].err_bit;
      stop_fr = vecs[i].stop_fr; stop_bit = vecs[i].stop_bit;
      run_pulse(vecs[i].nf);
      check($sformatf("v%0d_txstart_latency", i), {Busy, lnk.TxStart, Done}, 3'b110);
      check($sformatf("v%0d_restart_cleared", i), {Timeout, BitErrors, FrameErrors}, '0);
      wait_done($sformatf("v%0d_done", i), de);
      check($sformatf("v%0d_pass", i), {Busy, Pass}, {1'b0, vecs[i].pass});
      check($sformatf("v%0d_bit_errors", i), BitErrors, vecs[i].be);
      check($sformatf("v%0d_frame_errors", i), FrameErrors, vecs[i].fe);
      check($sformatf("v%0d_timeout", i), Timeout, vecs[i].to);
      check($sformatf("v%0d_txstarts", i), n_start, vecs[i].starts);
      if (i == 0) begin
        check("v0_first7_ones", cap[6:0], 7'h7F);
        check("v0_frame1_prbs", cap, frame1);
      end
      if (vecs[i].to) check($sformatf("v%0d_timeout_edges", i), de - last_rx_edge, TO);
    end
    flip_fr = -1; err_fr = -1; stop_fr = -1;

    // NumFrames == 0 from DONE with errors pending: immediate clean Done.
    run_pulse(0);
    check("nf0_done_pass", {Done, Pass, Busy, lnk.TxStart}, 4'b1100);
    check("nf0_counters", {Timeout, BitErrors, FrameErrors}, '0);
    repeat (5) @(negedge Clock);
    check("nf0_no_txstart", n_start, 0);

    // Run while busy must be ignored.
    run_pulse(1);
    repeat (10) @(negedge Clock);
    Run = 1'b1; NumFrames = CW'(5);
    @(negedge Clock);
    Run = 1'b0;
    wait_done("busy_run_done", de);
    check("busy_run_ignored", n_start, 1);
    check("busy_run_pass", Pass, 1'b1);

    // Reset in the middle of TX_DATA.
    run_pulse(2);
    repeat (30) @(negedge Clock);
    check("pre_reset_busy", Busy, 1'b1);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    check("midreset_outputs", {Busy, Done, Pass, Timeout, lnk.TxStart, lnk.TxData, BitErrors, FrameErrors}, '0);
    repeat (2) @(negedge Clock);
    check("midreset_stays_idle", {Busy, Done, lnk.TxStart}, 3'b000);
    repeat (8) @(negedge Clock);
    run_pulse(1);
    wait_done("post_reset_done", de);
    check("post_reset_frame", cap, frame1);
    check("post_reset_pass", {Pass, BitErrors, FrameErrors}, {1'b1, 32'h0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
